vga_timing_ctrl: RTL and testbench

- Generates 640x480@60 Hz VGA timing from the pixel clock.
- Drives pixel coordinates h_addr/v_addr to the downstream picture-lookup stage, which returns 24-bit RGB a fixed LAT cycles later.
- Re-aligns hsync/vsync/valid with the returned colour, blanks RGB outside the active area, and drives the DAC pins.

---
 rtl/vga_timing_ctrl.sv | 110 +++++++++++
 tb/tb_vga_timing_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA timing generator.
// Counters produce the pixel address for the picture stage. Sync, active and
// frame flags are delayed to line up with the colour that comes back LAT
// cycles later. RGB is forced to zero outside the active area.
module vga_timing_ctrl #(
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned H_ACT  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter int unsigned V_ACT  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned LAT    = 2     // picture-stage latency, 1..4
) (
    input  logic        clk_div,
    input  logic        clrn,
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

    localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOT - 1);
    localparam logic [9:0] H_SYNC_E  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_E  = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_B   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] V_ACT_B   = 10'(V_SYNC + V_BP);
    localparam logic [9:0] H_ACT_E   = 10'(H_SYNC + H_BP + H_ACT);
    localparam logic [9:0] V_ACT_E   = 10'(V_SYNC + V_BP + V_ACT);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        hs_raw;
    logic        vs_raw;
    logic        act_raw;
    logic        frm_raw;

    // Stage k holds the flags of the address issued k+1 cycles ago.
    logic [LAT:0] hs_pipe;
    logic [LAT:0] vs_pipe;
    logic [LAT:0] vld_pipe;
    logic [LAT:0] frm_pipe;
    logic [23:0]  rgb_q;

    // Pixel / line counters; line order is sync, back porch, active, front porch.
    always_ff @(posedge clk_div or negedge clrn) begin
        if (!clrn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Raw timing flags and pixel address decoded straight from the counters.
    always_comb begin
        hs_raw  = (h_cnt >= H_SYNC_E);
        vs_raw  = (v_cnt >= V_SYNC_E);
        act_raw = (h_cnt >= H_ACT_B) && (h_cnt < H_ACT_E) &&
                  (v_cnt >= V_ACT_B) && (v_cnt < V_ACT_E);
        h_addr  = act_raw ? h_cnt - H_ACT_B : '0;
        v_addr  = act_raw ? v_cnt - V_ACT_B : '0;
        frm_raw = act_raw && (h_cnt == H_ACT_B) && (v_cnt == V_ACT_B);
    end

    // Delay line for the flags; reset parks syncs inactive (high) and blanks.
    always_ff @(posedge clk_div or negedge clrn) begin
        if (!clrn) begin
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            vld_pipe <= '0;
            frm_pipe <= '0;
        end else begin
            hs_pipe  <= {hs_pipe[LAT-1:0],  hs_raw};
            vs_pipe  <= {vs_pipe[LAT-1:0],  vs_raw};
            vld_pipe <= {vld_pipe[LAT-1:0], act_raw};
            frm_pipe <= {frm_pipe[LAT-1:0], frm_raw};
        end
    end

    // Colour arrives while its act flag sits one stage short of the output,
    // so sampling it here lands it in the same cycle as that flag's output.
    always_ff @(posedge clk_div or negedge clrn) begin
        if (!clrn) rgb_q <= '0;
        else       rgb_q <= vld_pipe[LAT-1] ? vga_data : '0;
    end

    assign hsync       = hs_pipe[LAT];
    assign vsync       = vs_pipe[LAT];
    assign valid       = vld_pipe[LAT];
    assign frame_start = frm_pipe[LAT];
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: one full-size instance (LAT=2) for the real
// 640x480 boundaries and first-frame timing, three shrunken-timing instances
// (LAT=1,2,4) checked cycle by cycle over a whole frame, and one more shrunken
// instance that takes an asynchronous reset mid-line.
module tb_vga_timing_ctrl;

    // Shrunken timing: 4/3/8/2 horizontal, 2/3/5/2 vertical -> 17 x 12.
    localparam int S_HT     = 17;
    localparam int S_VT     = 12;
    localparam int S_END    = 250;
    localparam int FULL_END = 28800;

    logic clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    logic clrn   = 1'b0;
    logic clrn_r = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk_div) if (clrn) cyc <= cyc + 1;

    // ---------------- shrunken instances, LAT = 1, 2, 4 ----------------
    logic [2:0][9:0]  ha_s, va_s;
    logic [2:0]       hs_s, vs_s, vl_s, fs_s;
    logic [2:0][23:0] rgb_s, din_s;

    for (genvar gi = 0; gi < 3; gi++) begin : g_s
        localparam int unsigned L = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
        logic [23:0] d1, d2;
        always @(posedge clk_div) begin
            d1 <= {ha_s[gi][7:0], va_s[gi][7:0], 8'hA5};
            d2 <= d1;
        end
        assign din_s[gi] = (gi == 1) ? d2 : 24'hFFFFFF;
        vga_timing_ctrl #(.H_SYNC(4), .H_BP(3), .H_ACT(8), .H_FP(2),
                          .V_SYNC(2), .V_BP(3), .V_ACT(5), .V_FP(2), .LAT(L)) u_dut (
            .clk_div(clk_div), .clrn(clrn), .vga_data(din_s[gi]),
            .h_addr(ha_s[gi]), .v_addr(va_s[gi]),
            .hsync(hs_s[gi]), .vsync(vs_s[gi]), .valid(vl_s[gi]),
            .vga_r(rgb_s[gi][23:16]), .vga_g(rgb_s[gi][15:8]), .vga_b(rgb_s[gi][7:0]),
            .frame_start(fs_s[gi]));
    end

    // ---------------- full-size instance, LAT = 2 ----------------
    logic [9:0]  f_ha, f_va;
    logic        f_hs, f_vs, f_vl, f_fs;
    logic [23:0] f_rgb, f_d1, f_d2;
    always @(posedge clk_div) begin
        f_d1 <= {f_ha[7:0], f_va[7:0], 8'hA5};
        f_d2 <= f_d1;
    end
    vga_timing_ctrl u_full (
        .clk_div(clk_div), .clrn(clrn), .vga_data(f_d2),
        .h_addr(f_ha), .v_addr(f_va), .hsync(f_hs), .vsync(f_vs), .valid(f_vl),
        .vga_r(f_rgb[23:16]), .vga_g(f_rgb[15:8]), .vga_b(f_rgb[7:0]),
        .frame_start(f_fs));

    // ---------------- mid-line reset instance, LAT = 2 ----------------
    logic [9:0]  r_ha, r_va;
    logic        r_hs, r_vs, r_vl, r_fs;
    logic [23:0] r_rgb;
    vga_timing_ctrl #(.H_SYNC(4), .H_BP(3), .H_ACT(8), .H_FP(2),
                      .V_SYNC(2), .V_BP(3), .V_ACT(5), .V_FP(2), .LAT(2)) u_rst (
        .clk_div(clk_div), .clrn(clrn_r), .vga_data(24'hFFFFFF),
        .h_addr(r_ha), .v_addr(r_va), .hsync(r_hs), .vsync(r_vs), .valid(r_vl),
        .vga_r(r_rgb[23:16]), .vga_g(r_rgb[15:8]), .vga_b(r_rgb[7:0]),
        .frame_start(r_fs));

    // ---------------- reference model for the shrunken timing ----------------
    typedef struct packed {
        logic       hs, vs, act, fs;
        logic [9:0] ha, va;
    } raw_t;

    // Flags/address for counter step m (m < 0: idle values before release).
    function automatic raw_t s_raw(input int m);
        raw_t r;
        int   h, v;
        r = '{hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0, ha: 10'd0, va: 10'd0};
        if (m >= 0) begin
            h = m % S_HT;
            v = (m / S_HT) % S_VT;
            r.hs  = (h >= 4);
            r.vs  = (v >= 2);
            r.act = (h >= 7) && (h < 15) && (v >= 5) && (v < 10);
            if (r.act) begin
                r.ha = 10'(h - 7);
                r.va = 10'(v - 5);
            end
            r.fs = r.act && (h == 7) && (v == 5);
        end
        return r;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    function automatic logic [23:0] exp_rgb(input int k, input int m);
        raw_t e;
        e = s_raw(m);
        if (!e.act) return 24'h0;
        if (k == 1) return {e.ha[7:0], e.va[7:0], 8'hA5};
        return 24'hFFFFFF;
    endfunction

    function automatic bit in_win(input int k, input int n);
        return (n >= lat_of(k) + 1) && (n < lat_of(k) + 1 + S_HT * S_VT);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // ---------------- shrunken-instance monitor ----------------
    int s_err[3], s_fsn[3], s_hsl[3], s_hsf[3], s_vsl[3], s_vln[3];
    int s_runs[3], s_bad[3], s_run[3], s_mis[3];
    logic [2:0] hs_prev = '1, vs_prev = '1;

    always @(negedge clk_div) begin
        if (clrn && cyc >= 1 && cyc <= S_END) begin
            for (int k = 0; k < 3; k++) begin
                if ({hs_s[k], vs_s[k], vl_s[k], fs_s[k]} !==
                        {s_raw(cyc - lat_of(k) - 1).hs, s_raw(cyc - lat_of(k) - 1).vs,
                         s_raw(cyc - lat_of(k) - 1).act, s_raw(cyc - lat_of(k) - 1).fs} ||
                    rgb_s[k] !== exp_rgb(k, cyc - lat_of(k) - 1))
                    s_err[k] <= s_err[k] + 1;
                if (in_win(k, cyc)) begin
                    if (fs_s[k])                 s_fsn[k] <= s_fsn[k] + 1;
                    if (!hs_s[k])                s_hsl[k] <= s_hsl[k] + 1;
                    if (hs_prev[k] && !hs_s[k])  s_hsf[k] <= s_hsf[k] + 1;
                    if (!vs_s[k])                s_vsl[k] <= s_vsl[k] + 1;
                    if (vl_s[k])                 s_vln[k] <= s_vln[k] + 1;
                end
                if (vl_s[k]) begin
                    s_run[k] <= s_run[k] + 1;
                end else begin
                    if (s_run[k] != 0) begin
                        s_runs[k] <= s_runs[k] + 1;
                        if (s_run[k] != 8) s_bad[k] <= s_bad[k] + 1;
                    end
                    s_run[k] <= 0;
                end
                if (vs_s[k] != vs_prev[k] && !(hs_prev[k] && !hs_s[k]))
                    s_mis[k] <= s_mis[k] + 1;
            end
            hs_prev <= hs_s;
            vs_prev <= vs_s;
        end
    end

    // ---------------- full-size monitor ----------------
    int f_first_hs = -1, f_hsl1 = 0, f_vsl = 0, f_fsn = 0, f_first_fs = -1;
    int f_first_vl = -1, f_vln = 0;
    logic [23:0] f_rgb_fs = 24'h0, f_rgb_end = 24'h0;
    logic        f_vl_after = 1'b1, f_hs_prev = 1'b1;

    always @(negedge clk_div) begin
        if (clrn && cyc >= 1 && cyc <= FULL_END) begin
            if (f_hs_prev && !f_hs && f_first_hs < 0) f_first_hs <= cyc;
            f_hs_prev <= f_hs;
            if (!f_hs && cyc < 800) f_hsl1 <= f_hsl1 + 1;
            if (!f_vs) f_vsl <= f_vsl + 1;
            if (f_fs) begin
                f_fsn <= f_fsn + 1;
                if (f_first_fs < 0) begin
                    f_first_fs <= cyc;
                    f_rgb_fs   <= f_rgb;
                end
            end
            if (f_vl) begin
                f_vln <= f_vln + 1;
                if (f_first_vl < 0) f_first_vl <= cyc;
            end
            if (cyc == 28786) f_rgb_end  <= f_rgb;
            if (cyc == 28787) f_vl_after <= f_vl;
        end
    end

    // ---------------- address vectors ----------------
    typedef struct {
        int         cyc;
        bit         full;
        logic [9:0] ha;
        logic [9:0] va;
    } vec_t;
    vec_t vt [12];

    initial begin
        vt[0]  = '{91,    1'b0, 10'd0,   10'd0};  // (6,5)   last back-porch pixel
        vt[1]  = '{92,    1'b0, 10'd0,   10'd0};  // (7,5)   first active pixel
        vt[2]  = '{93,    1'b0, 10'd1,   10'd0};  // (8,5)
        vt[3]  = '{99,    1'b0, 10'd7,   10'd0};  // (14,5)  last active column
        vt[4]  = '{100,   1'b0, 10'd0,   10'd0};  // (15,5)  front porch
        vt[5]  = '{129,   1'b0, 10'd3,   10'd2};  // (10,7)
        vt[6]  = '{167,   1'b0, 10'd7,   10'd4};  // (14,9)  last active pixel
        vt[7]  = '{28143, 1'b1, 10'd0,   10'd0};  // (143,35)
        vt[8]  = '{28144, 1'b1, 10'd0,   10'd0};  // (144,35)
        vt[9]  = '{28145, 1'b1, 10'd1,   10'd0};  // (145,35)
        vt[10] = '{28783, 1'b1, 10'd639, 10'd0};  // (783,35)
        vt[11] = '{28784, 1'b1, 10'd0,   10'd0};  // (784,35)

        // Reset state with the clock running.
        repeat (3) @(negedge clk_div);
        chk("rst_full_hsync", int'(f_hs), 1);
        chk("rst_full_vsync", int'(f_vs), 1);
        chk("rst_full_valid", int'(f_vl), 0);
        chk("rst_full_fs",    int'(f_fs), 0);
        chk("rst_full_rgb",   int'(f_rgb), 0);
        chk("rst_full_haddr", int'(f_ha), 0);
        chk("rst_full_vaddr", int'(f_va), 0);
        chk("rst_s_hsync",    int'(hs_s), 7);
        chk("rst_s_vsync",    int'(vs_s), 7);
        chk("rst_s_valid",    int'(vl_s), 0);
        chk("rst_s4_rgb",     int'(rgb_s[2]), 0);
        #1 clrn = 1'b1; clrn_r = 1'b1;

        fork
            begin : addr_table
                for (int i = 0; i < 12; i++) begin
                    while (cyc < vt[i].cyc) @(negedge clk_div);
                    if (vt[i].full) begin
                        chk($sformatf("full_haddr@%0d", vt[i].cyc), int'(f_ha), int'(vt[i].ha));
                        chk($sformatf("full_vaddr@%0d", vt[i].cyc), int'(f_va), int'(vt[i].va));
                    end else begin
                        chk($sformatf("s2_haddr@%0d", vt[i].cyc), int'(ha_s[1]), int'(vt[i].ha));
                        chk($sformatf("s2_vaddr@%0d", vt[i].cyc), int'(va_s[1]), int'(vt[i].va));
                    end
                end
            end
            begin : midline_reset
                int first_hs, first_vs, first_fs;
                first_hs = -1; first_vs = -1; first_fs = -1;
                while (cyc < 129) @(negedge clk_div);
                chk("mr_pre_valid", int'(r_vl), 1);
                chk("mr_pre_rgb",   int'(r_rgb), 24'hFFFFFF);
                chk("mr_pre_haddr", int'(r_ha), 3);
                #2 clrn_r = 1'b0;
                #1;
                chk("mr_async_valid", int'(r_vl), 0);
                chk("mr_async_rgb",   int'(r_rgb), 0);
                chk("mr_async_haddr", int'(r_ha), 0);
                chk("mr_async_vaddr", int'(r_va), 0);
                chk("mr_async_hsync", int'(r_hs), 1);
                repeat (3) @(negedge clk_div);
                chk("mr_hold_hsync", int'(r_hs), 1);
                chk("mr_hold_fs",    int'(r_fs), 0);
                #1 clrn_r = 1'b1;
                for (int i = 1; i <= 150; i++) begin
                    @(negedge clk_div);
                    if (first_hs < 0 && !r_hs) first_hs = i;
                    if (first_vs < 0 && !r_vs) first_vs = i;
                    if (first_fs < 0 &&  r_fs) first_fs = i;
                end
                chk("mr_first_hsync_fall", first_hs, 3);
                chk("mr_first_vsync_fall", first_vs, 3);
                chk("mr_first_frame_start", first_fs, 5 * S_HT + 7 + 3);
            end
        join

        while (cyc <= FULL_END + 1) @(negedge clk_div);

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("s%0d_cycle_err",   lat_of(k)), s_err[k], 0);
            chk($sformatf("s%0d_frame_start", lat_of(k)), s_fsn[k], 1);
            chk($sformatf("s%0d_hsync_low",   lat_of(k)), s_hsl[k], 4 * S_VT);
            chk($sformatf("s%0d_hsync_falls", lat_of(k)), s_hsf[k], S_VT);
            chk($sformatf("s%0d_vsync_low",   lat_of(k)), s_vsl[k], 2 * S_HT);
            chk($sformatf("s%0d_valid_cnt",   lat_of(k)), s_vln[k], 8 * 5);
            chk($sformatf("s%0d_valid_runs",  lat_of(k)), s_runs[k], 5);
            chk($sformatf("s%0d_bad_runs",    lat_of(k)), s_bad[k], 0);
            chk($sformatf("s%0d_vs_misalign", lat_of(k)), s_mis[k], 0);
        end

        chk("full_first_hsync_fall", f_first_hs, 3);
        chk("full_hsync_low_line0",  f_hsl1, 96);
        chk("full_vsync_low",        f_vsl, 1600);
        chk("full_frame_start_cnt",  f_fsn, 1);
        chk("full_frame_start_cyc",  f_first_fs, 35 * 800 + 144 + 3);
        chk("full_first_valid_cyc",  f_first_vl, 35 * 800 + 144 + 3);
        chk("full_valid_line0",      f_vln, 640);
        chk("full_rgb_pixel00",      int'(f_rgb_fs), 24'h0000A5);
        chk("full_rgb_pixel639",     int'(f_rgb_end), 24'h7F00A5);
        chk("full_valid_after_line", int'(f_vl_after), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d expected run to finish by cyc=%0d", cyc, FULL_END + 2);
        $fatal(1, "watchdog");
    end

endmodule
